phy_rst_seq: RTL and testbench

PHY reset sequencer for the Ethernet PHY/MAC bring-up path. Issues the `sys_reset` pulse to the Xilinx PHY, tracks the PHY's RX/TX reset outputs through a full assert/release cycle, then waits for RX/TX status good. Retries on timeout and reports done, link-good or fail. It is the initiating side of the PHY reset handshake, next to the PHY wrapper in the board-level reset tree.

---
 rtl/phy_rst_seq_if.sv | 25 ++
 rtl/phy_rst_seq.sv | 204 ++++++++++++++++++++
 tb/tb_phy_rst_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_rst_seq_if.sv
// PHY reset sequencer bundle: start request, PHY reset/status
// inputs and the sequencer's reset request and status outputs.
interface phy_rst_seq_if;
    logic       start;
    logic       rst_rx;
    logic       rst_tx;
    logic       stat_rx;
    logic       stat_tx;
    logic       sys_reset;
    logic       busy;
    logic       done;
    logic       link_good;
    logic       fail;
    logic [3:0] retry_cnt;

    modport master (
        input  start, rst_rx, rst_tx, stat_rx, stat_tx,
        output sys_reset, busy, done, link_good, fail, retry_cnt
    );

    modport slave (
        output start, rst_rx, rst_tx, stat_rx, stat_tx,
        input  sys_reset, busy, done, link_good, fail, retry_cnt
    );
endinterface

// File: rtl/phy_rst_seq.sv
// PHY reset sequencer: pulses sys_reset, follows the PHY reset
// assert/release cycle, waits for status good, retries on timeout.
module phy_rst_seq #(
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned AUTO_START       = 1
) (
    input  logic          clk,
    input  logic          reset_,
    phy_rst_seq_if.master phy
);

    localparam int unsigned PW =
        (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    R_MAX  = 4'(MAX_RETRY);

    localparam int IDLE      = 0;
    localparam int PULSE     = 1;
    localparam int WAIT_RST  = 2;
    localparam int WAIT_STAT = 3;
    localparam int DONE      = 4;
    localparam int FAIL      = 5;

    localparam logic [5:0] S_IDLE      = 6'b000001;
    localparam logic [5:0] S_PULSE     = 6'b000010;
    localparam logic [5:0] S_WAIT_RST  = 6'b000100;
    localparam logic [5:0] S_WAIT_STAT = 6'b001000;
    localparam logic [5:0] S_DONE      = 6'b010000;
    localparam logic [5:0] S_FAIL      = 6'b100000;

    logic [5:0]    st;
    logic [5:0]    st_nxt;
    logic [3:0]    sync_a;
    logic [3:0]    sync_b;
    logic [1:0]    rst_d;
    logic [1:0]    auto_sr;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [3:0]    rcnt;
    logic          rx_r;
    logic          rx_f;
    logic          tx_f;
    logic          stat_q;

    logic rx_s;
    logic tx_s;
    logic stat_ok;
    logic rx_rise;
    logic rx_fall;
    logic tx_fall;
    logic rst_seen;
    logic tmo;
    logic auto_go;
    logic go;
    logic seq_start;
    logic retry;
    logic enter_pulse;

    assign rx_s     = sync_b[0];
    assign tx_s     = sync_b[1];
    assign stat_ok  = sync_b[2] & sync_b[3];
    assign rx_rise  = rx_s & ~rst_d[0];
    assign rx_fall  = ~rx_s & rst_d[0];
    assign tx_fall  = ~tx_s & rst_d[1];
    assign rst_seen = rx_r & rx_f & tx_f;
    assign tmo      = (tcnt == T_LAST);
    assign auto_go  = (AUTO_START != 0) & auto_sr[0] & ~auto_sr[1];
    assign go       = phy.start | auto_go;

    assign enter_pulse = st_nxt[PULSE] & ~st[PULSE];

    // Bring the asynchronous PHY signals into clk, keep a delayed copy
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync_a <= '0;
            sync_b <= '0;
            rst_d  <= '0;
        end else begin
            sync_a <= {phy.stat_tx, phy.stat_rx, phy.rst_tx, phy.rst_rx};
            sync_b <= sync_a;
            rst_d  <= sync_b[1:0];
        end
    end

    // One-shot start request in the first full cycle after reset release
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            auto_sr <= '0;
        end else begin
            auto_sr <= {auto_sr[0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            st <= S_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Next-state logic; an exit condition beats a same-cycle timeout
    always_comb begin
        st_nxt    = st;
        seq_start = 1'b0;
        retry     = 1'b0;
        unique case (1'b1)
            st[IDLE], st[DONE], st[FAIL]: begin
                if (go) begin
                    st_nxt    = S_PULSE;
                    seq_start = 1'b1;
                end
            end
            st[PULSE]: begin
                if (pcnt == P_LAST) begin
                    st_nxt = S_WAIT_RST;
                end
            end
            st[WAIT_RST]: begin
                if (rst_seen) begin
                    st_nxt = S_WAIT_STAT;
                end else if (tmo) begin
                    if (rcnt < R_MAX) begin
                        st_nxt = S_PULSE;
                        retry  = 1'b1;
                    end else begin
                        st_nxt = S_FAIL;
                    end
                end
            end
            st[WAIT_STAT]: begin
                if (stat_ok) begin
                    st_nxt = S_DONE;
                end else if (tmo) begin
                    if (rcnt < R_MAX) begin
                        st_nxt = S_PULSE;
                        retry  = 1'b1;
                    end else begin
                        st_nxt = S_FAIL;
                    end
                end
            end
            default: begin
                st_nxt = S_IDLE;
            end
        endcase
    end

    // Pulse/timeout/retry counters, PHY reset edge flags, status sample
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pcnt   <= '0;
            tcnt   <= '0;
            rcnt   <= '0;
            rx_r   <= 1'b0;
            rx_f   <= 1'b0;
            tx_f   <= 1'b0;
            stat_q <= 1'b0;
        end else begin
            stat_q <= stat_ok;
            if (seq_start) begin
                rcnt <= '0;
            end else if (retry) begin
                rcnt <= rcnt + 4'd1;
            end
            if (enter_pulse) begin
                pcnt <= '0;
            end else if (st[PULSE] && pcnt != P_LAST) begin
                pcnt <= pcnt + 1'b1;
            end
            if (st[PULSE] || seq_start) begin
                tcnt <= '0;
            end else if ((st[WAIT_RST] || st[WAIT_STAT]) && !tmo) begin
                tcnt <= tcnt + 1'b1;
            end
            if (enter_pulse) begin
                rx_r <= 1'b0;
                rx_f <= 1'b0;
                tx_f <= 1'b0;
            end else if (st[PULSE] || st[WAIT_RST]) begin
                rx_r <= rx_r | rx_rise;
                rx_f <= rx_f | (rx_fall & rx_r);
                tx_f <= tx_f | tx_fall;
            end
        end
    end

    // Outputs decoded straight from the state and counter flops
    always_comb begin
        phy.sys_reset = st[PULSE];
        phy.busy      = st[PULSE] | st[WAIT_RST] | st[WAIT_STAT];
        phy.done      = st[DONE];
        phy.fail      = st[FAIL];
        phy.link_good = st[DONE] & stat_q;
        phy.retry_cnt = rcnt;
    end

endmodule

// File: tb/tb_phy_rst_seq.sv
// Scoreboard bench for phy_rst_seq: a cycle-level reference model
// predicts every output cycle, a negedge monitor pops and compares.
module tb_phy_rst_seq;

    localparam int P  = 4;
    localparam int T  = 20;
    localparam int R  = 2;
    localparam int HN = 16384;

    typedef struct packed {
        logic start;
        logic rrx;
        logic rtx;
        logic srx;
        logic stx;
        logic rst;
    } in_t;

    typedef struct packed {
        logic       sr;
        logic       busy;
        logic       done;
        logic       lg;
        logic       fail;
        logic [3:0] rc;
    } out_t;

    logic clk = 1'b0;
    logic reset_;
    logic reset_a;

    always #5 clk = ~clk;

    phy_rst_seq_if bus ();
    phy_rst_seq_if bus_a ();

    phy_rst_seq #(
        .RST_PULSE_CYCLES(P),
        .TIMEOUT_CYCLES  (T),
        .MAX_RETRY       (R),
        .AUTO_START      (0)
    ) dut (
        .clk   (clk),
        .reset_(reset_),
        .phy   (bus.master)
    );

    phy_rst_seq #(
        .RST_PULSE_CYCLES(P),
        .TIMEOUT_CYCLES  (T),
        .MAX_RETRY       (R),
        .AUTO_START      (1)
    ) dut_a (
        .clk   (clk),
        .reset_(reset_a),
        .phy   (bus_a.master)
    );

    int   vecs = 0;
    int   errs = 0;
    out_t exp_q[$];
    in_t  hist[HN];
    int   cyc = 0;
    int   last_rst = 0;
    in_t  cur;

    // reference model state: phase 0 idle,1 pulse,2 wait rst,3 wait stat,4 done,5 fail
    int ph = 0;
    int rc = 0;
    int p0 = 0;
    int w0 = 0;
    bit fr = 0;
    bit ff = 0;
    bit tf = 0;
    bit lg = 0;

    int pulses = 0;
    int pw_run = 0;
    int pw_last = 0;
    logic sr_prev = 1'b0;

    out_t m_exp;
    out_t m_got;

    // Input value the DUT sees for cycle j; anything up to the last reset reads as 0.
    function automatic in_t hget(int j);
        if (j < 0 || j <= last_rst) return '0;
        return hist[j];
    endfunction

    task automatic model_edge();
        in_t  c, a, b;
        bit   rise, fall, txf, sok;
        int   e, nph;
        out_t o;
        c = hget(cyc);
        a = hget(cyc - 2);
        b = hget(cyc - 3);
        e = cyc + 1;
        if (!c.rst) begin
            ph = 0; rc = 0; fr = 0; ff = 0; tf = 0; lg = 0;
        end else begin
            rise = a.rrx & ~b.rrx;
            fall = ~a.rrx & b.rrx;
            txf  = ~a.rtx & b.rtx;
            sok  = a.srx & a.stx;
            nph  = ph;
            case (ph)
                0, 4, 5: if (c.start) begin nph = 1; rc = 0; end
                1: if (e == p0 + P) begin nph = 2; w0 = e; end
                2, 3: begin
                    if (ph == 2 && fr && ff && tf) nph = 3;
                    else if (ph == 3 && sok) nph = 4;
                    else if (e == w0 + T) begin
                        if (rc < R) begin rc++; nph = 1; end
                        else nph = 5;
                    end
                end
                default: ;
            endcase
            if (nph == 1 && ph != 1) begin
                p0 = e; fr = 0; ff = 0; tf = 0;
            end else if (ph == 1 || ph == 2) begin
                ff = ff | (fall & fr);
                fr = fr | rise;
                tf = tf | txf;
            end
            lg = (nph == 4) && sok;
            ph = nph;
        end
        o.sr   = (ph == 1);
        o.busy = (ph >= 1 && ph <= 3);
        o.done = (ph == 4);
        o.lg   = lg;
        o.fail = (ph == 5);
        o.rc   = 4'(rc);
        exp_q.push_back(o);
    endtask

    task automatic drive_cur();
        reset_        = cur.rst;
        bus.start     = cur.start;
        bus.rst_rx    = cur.rrx;
        bus.rst_tx    = cur.rtx;
        bus.stat_rx   = cur.srx;
        bus.stat_tx   = cur.stx;
        hist[cyc]     = cur;
        if (!cur.rst) last_rst = cyc;
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            cyc++;
            #1;
            drive_cur();
        end
    endtask

    task automatic chk(string name, int got, int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic async_reset(int hold);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        cur.rst = 1'b0;
        drive_cur();
        exp_q[exp_q.size() - 1] = '0;
        #1;
        chk("areset_outs",
            int'({bus.sys_reset, bus.busy, bus.done, bus.link_good,
                  bus.fail, bus.retry_cnt}), 0);
        tick(hold);
        cur.rst = 1'b1;
    endtask

    task automatic phy_quiet();
        cur.start = 0; cur.rrx = 0; cur.rtx = 0; cur.srx = 0; cur.stx = 0;
    endtask

    // Scoreboard monitor: one expected vector per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_got = {bus.sys_reset, bus.busy, bus.done, bus.link_good,
                     bus.fail, bus.retry_cnt};
            vecs++;
            if (m_got !== m_exp) begin
                errs++;
                $display("FAIL outputs cyc=%0d got sr=%b busy=%b done=%b lg=%b fail=%b rc=%0d exp sr=%b busy=%b done=%b lg=%b fail=%b rc=%0d",
                         cyc, m_got.sr, m_got.busy, m_got.done, m_got.lg,
                         m_got.fail, m_got.rc, m_exp.sr, m_exp.busy,
                         m_exp.done, m_exp.lg, m_exp.fail, m_exp.rc);
            end
        end
    end

    // sys_reset pulse counter and width of the last pulse
    always @(negedge clk) begin
        if (bus.sys_reset) begin
            if (!sr_prev) pulses++;
            pw_run++;
        end else if (sr_prev) begin
            pw_last = pw_run;
            pw_run  = 0;
        end
        sr_prev = bus.sys_reset;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        cur       = '0;
        reset_    = 1'b0;
        reset_a   = 1'b0;
        bus.start = 0; bus.rst_rx = 0; bus.rst_tx = 0;
        bus.stat_rx = 0; bus.stat_tx = 0;
        bus_a.start = 0; bus_a.rst_rx = 0; bus_a.rst_tx = 0;
        bus_a.stat_rx = 0; bus_a.stat_tx = 0;
        hist[0]   = '0;

        tick(3);
        cur.rst = 1'b1;
        tick(5);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_rc", int'(bus.retry_cnt), 0);

        // nominal
        cur.start = 1; tick(1); cur.start = 0;
        tick(1);
        cur.rrx = 1; cur.rtx = 1; tick(8);
        cur.rrx = 0; tick(2);
        cur.rtx = 0; tick(2);
        cur.srx = 1; cur.stx = 1; tick(12);
        chk("nom_done", int'(bus.done), 1);
        chk("nom_link_good", int'(bus.link_good), 1);
        chk("nom_rc", int'(bus.retry_cnt), 0);
        cur.stx = 0; tick(5);
        chk("nom_lost_lg", int'(bus.link_good), 0);
        chk("nom_lost_done", int'(bus.done), 1);

        // randomized PHY timing
        for (int i = 0; i < 10; i++) begin
            phy_quiet(); tick(4);
            cur.start = 1; tick(1); cur.start = 0;
            tick($urandom_range(0, 3));
            cur.rrx = 1; tick($urandom_range(0, 1));
            cur.rtx = 1; tick($urandom_range(2, 7));
            cur.rrx = 0; tick($urandom_range(0, 4));
            cur.rtx = 0; tick($urandom_range(0, 6));
            cur.srx = 1; tick($urandom_range(0, 2));
            cur.stx = 1; tick($urandom_range(6, 10));
            if ($urandom_range(0, 1) == 1) begin
                cur.srx = 0; tick(2); cur.srx = 1; tick(5);
            end
            tick(3 * (P + T));
        end

        // ordering: rx falls without a rise inside the attempt
        phy_quiet(); tick(3);
        cur.rrx = 1; cur.rtx = 1; cur.srx = 1; cur.stx = 1; tick(5);
        cur.start = 1; tick(1); cur.start = 0;
        tick(6);
        cur.rrx = 0; tick(2);
        cur.rtx = 0; tick(6);
        chk("ord_not_done", int'(bus.done), 0);
        chk("ord_busy", int'(bus.busy), 1);
        cur.rrx = 1; tick(2);
        cur.rrx = 0; tick(7);
        chk("ord_done", int'(bus.done), 1);
        chk("ord_rc", int'(bus.retry_cnt), 0);

        // retry then pass
        phy_quiet(); tick(3);
        pc = pulses;
        cur.start = 1; tick(1); cur.start = 0;
        tick(P + T + 1);
        cur.rrx = 1; cur.rtx = 1; tick(4);
        cur.rrx = 0; tick(1);
        cur.rtx = 0; cur.srx = 1; cur.stx = 1; tick(12);
        chk("retry_done", int'(bus.done), 1);
        chk("retry_rc", int'(bus.retry_cnt), 1);
        chk("retry_pulses", pulses - pc, 2);

        // fail
        phy_quiet(); tick(3);
        pc = pulses;
        cur.start = 1; tick(1); cur.start = 0;
        tick(3 * (P + T) + 6);
        chk("fail_flag", int'(bus.fail), 1);
        chk("fail_rc", int'(bus.retry_cnt), R);
        chk("fail_busy", int'(bus.busy), 0);
        chk("fail_pulses", pulses - pc, R + 1);
        chk("fail_pulse_w", pw_last, P);
        cur.start = 1; tick(1); cur.start = 0; tick(1);
        chk("fail_restart_flag", int'(bus.fail), 0);
        chk("fail_restart_sr", int'(bus.sys_reset), 1);
        tick(3 * (P + T) + 6);

        // collision: status good exactly in the timeout cycle, start held in PULSE
        phy_quiet(); tick(3);
        pc = pulses;
        cur.start = 1; tick(1);
        cur.rrx = 1; cur.rtx = 1; tick(3);
        cur.start = 0; tick(3);
        cur.rrx = 0; cur.rtx = 0; tick(15);
        cur.srx = 1; cur.stx = 1; tick(10);
        chk("coll_done", int'(bus.done), 1);
        chk("coll_rc", int'(bus.retry_cnt), 0);
        chk("coll_pulses", pulses - pc, 1);

        // async reset mid-PULSE and mid-WAIT_STAT
        phy_quiet(); tick(3);
        cur.start = 1; tick(1); cur.start = 0; tick(2);
        chk("pulse_sr", int'(bus.sys_reset), 1);
        async_reset(2);
        tick(4);
        cur.start = 1; tick(1); cur.start = 0;
        cur.rrx = 1; cur.rtx = 1; tick(3);
        cur.rrx = 0; cur.rtx = 0; tick(10);
        chk("ws_busy", int'(bus.busy), 1);
        async_reset(3);
        tick(5);
        chk("post_reset_busy", int'(bus.busy), 0);

        // auto-start instance
        reset_a = 1'b1;
        tick(1);
        chk("auto_e1_sr", int'(bus_a.sys_reset), 0);
        tick(1);
        chk("auto_e2_sr", int'(bus_a.sys_reset), 1);
        tick(3);
        chk("auto_e5_sr", int'(bus_a.sys_reset), 1);
        tick(1);
        chk("auto_e6_sr", int'(bus_a.sys_reset), 0);
        chk("auto_e6_busy", int'(bus_a.busy), 1);

        tick(2);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
